alu_arbiter: RTL

Shares the single combinational 32-bit ALU between two requesters: requester 0 is the CPU execute stage and requester 1 is the address/auxiliary unit. Round-robin arbitration with valid/ready handshakes on both the request and response sides. Each request passes through a registered issue stage that drives the ALU, then a registered response stage that returns the result and zero flag to the requester that issued it. The block screens illegal opcodes so the ALU never sees an undefined control value.

---
 rtl/alu_arbiter_if.sv | 62 ++++++
 rtl/alu_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Handshake and ALU-drive bundle between the two requesters, the shared ALU and the arbiter.
// Pure wiring; no latency of its own.
// Backpressure is carried by the reqN_ready / rspN_ready signals it groups.
interface alu_arbiter_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
);
    // Request side, one set per requester (0 = CPU execute, 1 = address/aux unit).
    logic              req0_valid;
    logic              req0_ready;
    logic [CTRL_W-1:0] req0_op;
    logic [WIDTH-1:0]  req0_a;
    logic [WIDTH-1:0]  req0_b;
    logic              req1_valid;
    logic              req1_ready;
    logic [CTRL_W-1:0] req1_op;
    logic [WIDTH-1:0]  req1_a;
    logic [WIDTH-1:0]  req1_b;

    // Shared combinational ALU.
    logic [WIDTH-1:0]  alu_src_A;
    logic [WIDTH-1:0]  alu_src_B;
    logic [CTRL_W-1:0] alu_control;
    logic [WIDTH-1:0]  alu_result;
    logic              alu_zero;

    // Response side, one set per requester.
    logic              rsp0_valid;
    logic              rsp0_ready;
    logic [WIDTH-1:0]  rsp0_result;
    logic              rsp0_zero;
    logic              rsp0_err;
    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [WIDTH-1:0]  rsp1_result;
    logic              rsp1_zero;
    logic              rsp1_err;

    // Environment side: requesters, response consumers and the ALU itself.
    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  alu_src_A, alu_src_B, alu_control,
        output alu_result, alu_zero,
        input  rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
        input  rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
        output rsp0_ready, rsp1_ready
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req0_ready, req1_ready,
        output alu_src_A, alu_src_B, alu_control,
        input  alu_result, alu_zero,
        output rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
        output rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
        input  rsp0_ready, rsp1_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational 32-bit ALU between two requesters, with opcode screening.
// Latency: 2 cycles acceptance-to-response (issue stage S1, response stage S2); 1 op/cycle sustained.
// Backpressure: a stalled response freezes S2, then S1, then drops both reqN_ready; at most 2 in flight.
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4,
    parameter int MAX_OP = 9
) (
    input  logic          clock,
    input  logic          reset,
    alu_arbiter_if.slave  bus
);

    localparam logic [CTRL_W-1:0] MAX_OP_C = CTRL_W'(MAX_OP);

    // Issue stage: the operation currently presented to the ALU.
    typedef struct packed {
        logic              id;
        logic [CTRL_W-1:0] op;
        logic [WIDTH-1:0]  a;
        logic [WIDTH-1:0]  b;
        logic              err;
    } s1_t;

    // Response stage: the captured ALU output waiting for its requester.
    typedef struct packed {
        logic              id;
        logic [WIDTH-1:0]  result;
        logic              zero;
        logic              err;
    } s2_t;

    logic s1_v;
    logic s2_v;
    logic ptr;
    s1_t  s1_q;
    s2_t  s2_q;

    logic grant0;
    logic grant1;
    logic drain;
    logic s2_free;
    logic s1_adv;
    logic s1_free;
    logic acc0;
    logic acc1;
    logic accept;
    logic [CTRL_W-1:0] in_op;
    s1_t  s1_new;
    s2_t  s2_new;

    // Round-robin grant: a lone requester always wins, a tie goes to the requester ptr names.
    always_comb begin
        grant0 = bus.req0_valid & (!bus.req1_valid | !ptr);
        grant1 = bus.req1_valid & (!bus.req0_valid |  ptr);
    end

    // Pipeline flow: a slot is free when empty or when its occupant leaves this same cycle,
    // which lets drain, advance and acceptance all happen together without a bubble.
    always_comb begin
        drain   = s2_v & (s2_q.id ? bus.rsp1_ready : bus.rsp0_ready);
        s2_free = !s2_v | drain;
        s1_adv  = s1_v & s2_free;
        s1_free = !s1_v | s1_adv;
    end

    // Ready is masked during reset so a requester never believes a discarded request was taken.
    assign bus.req0_ready = grant0 & s1_free & !reset;
    assign bus.req1_ready = grant1 & s1_free & !reset;

    // Acceptance decode and S1 load value; illegal opcodes are flagged and replaced by add
    // so the ALU never sees an undefined control code.
    always_comb begin
        acc0   = bus.req0_valid & bus.req0_ready;
        acc1   = bus.req1_valid & bus.req1_ready;
        accept = acc0 | acc1;
        in_op  = acc1 ? bus.req1_op : bus.req0_op;

        s1_new     = '0;
        s1_new.id  = acc1;
        s1_new.a   = acc1 ? bus.req1_a : bus.req0_a;
        s1_new.b   = acc1 ? bus.req1_b : bus.req0_b;
        s1_new.err = (in_op > MAX_OP_C);
        s1_new.op  = s1_new.err ? '0 : in_op;
    end

    // S2 load value: screened operations return a fixed result=0, zero=1 instead of the ALU output.
    always_comb begin
        s2_new    = '0;
        s2_new.id = s1_q.id;
        if (s1_q.err) begin
            s2_new.result = '0;
            s2_new.zero   = 1'b1;
            s2_new.err    = 1'b1;
        end else begin
            s2_new.result = bus.alu_result;
            s2_new.zero   = bus.alu_zero;
            s2_new.err    = 1'b0;
        end
    end

    // ALU is driven only while S1 holds an operation; idle drive is all zeros.
    always_comb begin
        bus.alu_src_A   = '0;
        bus.alu_src_B   = '0;
        bus.alu_control = '0;
        if (s1_v) begin
            bus.alu_src_A   = s1_q.a;
            bus.alu_src_B   = s1_q.b;
            bus.alu_control = s1_q.op;
        end
    end

    // Response steering: S2 is shown only to the requester that issued it, zeros to the other.
    always_comb begin
        bus.rsp0_valid  = s2_v & !s2_q.id;
        bus.rsp1_valid  = s2_v &  s2_q.id;
        bus.rsp0_result = bus.rsp0_valid ? s2_q.result : '0;
        bus.rsp0_zero   = bus.rsp0_valid & s2_q.zero;
        bus.rsp0_err    = bus.rsp0_valid & s2_q.err;
        bus.rsp1_result = bus.rsp1_valid ? s2_q.result : '0;
        bus.rsp1_zero   = bus.rsp1_valid & s2_q.zero;
        bus.rsp1_err    = bus.rsp1_valid & s2_q.err;
    end

    // Stage and pointer registers; reset discards anything in flight and gives requester 0 priority.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            ptr  <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            if (accept) begin
                s1_q <= s1_new;
                s1_v <= 1'b1;
                ptr  <= !acc1;
            end else if (s1_adv) begin
                s1_v <= 1'b0;
            end

            if (s1_adv) begin
                s2_q <= s2_new;
                s2_v <= 1'b1;
            end else if (drain) begin
                s2_v <= 1'b0;
            end
        end
    end

endmodule
